sd_upsize_gather: RTL
=====================

# sd_upsize_gather

Srdy/drdy width-upsizing stage that packs `ratio` narrow `width`-bit beats into one wide word, with early flush on end-of-packet. It sits directly upstream of the small FIFO and drives its consumer-side interface. The FIFO data width is set to `width*ratio + ratio + 1`, carrying data, lane mask and EOP, so the FIFO stores whole wide words. Single clock domain; all outputs are registered except the `c_drdy` pass-through term.

## Interface
- `width`, default 8: narrow input beat width in bits.
- `ratio`, default 4: beats per output word. Must be ≥ 2.
- `clk`, input, 1 bit: clock. All logic is on the rising edge.
- `reset_n`, input, 1 bit: reset. Synchronous, active-low.
- `c_srdy`, input, 1 bit: an input beat is valid.
- `c_drdy`, output, 1 bit: the block accepts the input beat.
- `c_data`, input, `width` bits: the input beat.
- `c_eop`, input, 1 bit: the beat is the last of its packet.
- `p_srdy`, output, 1 bit: the output word is valid.
- `p_drdy`, input, 1 bit: downstream (FIFO `c_drdy`) accepts the output word.
- `p_data`, output, `width*ratio` bits: the packed word. Lane k is `[k*width +: width]`.
- `p_mask`, output, `ratio` bits: bit k set means lane k holds a valid beat.
- `p_eop`, output, 1 bit: the word ends a packet.

## Operation
- State:
  - Lane counter `cnt`, `$clog2(ratio)` bits.
  - Accumulator data and mask registers.
  - Output register: `p_data`, `p_mask`, `p_eop`, with a full flag driving `p_srdy`.
- Input transfer happens when `c_srdy & c_drdy`.
  - Write `c_data` into accumulator lane `cnt` and set mask bit `cnt`.
- Completion condition: transfer with `cnt == ratio-1` or with `c_eop == 1`. On completion:
  - Load the output register with the accumulator, including the current beat in lane `cnt`.
  - `p_mask` = accumulated mask OR (1<<`cnt`); `p_eop` = `c_eop`.
  - Set full. Set `cnt` to 0. Clear accumulator data and mask to 0.
  - Unused lanes of `p_data` are 0.
- On a non-completing transfer, `cnt` increments by 1.
- Lane order: the first beat of a word goes in lane 0 (LSBs).
- Output transfer happens when `p_srdy & p_drdy`. Full clears unless a completion occurs in the same cycle, in which case the output is reloaded and full stays 1.
- `c_drdy = !full | p_drdy`. This is the only combinational path (`p_drdy` to `c_drdy`). Non-completing beats obey the same rule, which keeps `c_drdy` independent of `c_data` and `c_eop`.
- While `p_srdy=1` and `p_drdy=0`: `p_data`, `p_mask` and `p_eop` are held stable.
- EOP on the very first beat gives `p_mask = 1`, with only lane 0 populated.
- Partial words never flush without EOP; there is no timeout.

## Timing
- Reset (`reset_n=0` at a rising edge):
  - `cnt`=0; accumulator data and mask = 0.
  - full=0, so `p_srdy`=0; `p_data`=0, `p_mask`=0, `p_eop`=0.
  - `c_drdy` = 1 combinationally, since full=0.
- Reset mid-operation discards the partial accumulator and any unconsumed output word. No output is produced for them.
- Latency: a completing input transfer on edge N gives `p_srdy=1` in the cycle after edge N.
- Throughput: one beat per cycle sustained when `p_drdy` is held 1. Output rate is one word per `ratio` beats, or fewer for short packets.
- Back-to-back short packets: a completion every cycle with `p_drdy=1` sustains one word per cycle.
- Backpressure:
  - With full=1 and `p_drdy=0`, `c_drdy=0` and the accumulator and `cnt` do not change.
  - Upstream holds `c_srdy` and `c_data`. The next beat is accepted in the first cycle `p_drdy=1`.
- `cnt` wraps from `ratio-1` to 0 only via completion; it never exceeds `ratio-1`.

## Test plan
- **Full word, no backpressure** (`ratio`=4, `width`=8).
  - Stimulus: beats 0x11, 0x22, 0x33, 0x44 with EOP on 0x44, `p_drdy`=1.
  - Required: one word, `p_data`=0x44332211, `p_mask`=4'b1111, `p_eop`=1, `p_srdy` high one cycle after the fourth beat.
- **Short packet.**
  - Stimulus: beats 0xAA, 0xBB with EOP on 0xBB.
  - Required: `p_data`=0x0000BBAA, `p_mask`=4'b0011, `p_eop`=1; `cnt` returns to 0.
- **EOP on first beat, then a full packet.**
  - Stimulus: 0x5A with EOP, followed immediately by 0x01..0x04 with EOP on 0x04.
  - Required:
    - First word: `p_mask`=4'b0001, `p_data`=0x0000005A.
    - Second word: 0x04030201, `p_mask`=4'b1111.
- **Backpressure.**
  - Stimulus: 8 beats 0x01..0x08, no EOP; `p_drdy`=0 for 10 cycles after the first word completes.
  - Required:
    - `c_drdy`=0 while full; first word 0x04030201 held stable throughout.
    - After `p_drdy` rises, second word 0x08070605 with `p_eop`=0. No beat lost or duplicated.
- **Reset mid-word.**
  - Stimulus: beats 0x10, 0x20 accepted, then `reset_n`=0 for 1 cycle, then 0x30..0x33 with EOP on 0x33.
  - Required:
    - All outputs are 0 in the cycle after reset.
    - Next word is 0x33323130, `p_mask`=4'b1111; 0x10 and 0x20 never appear.
- **Random stress.**
  - Stimulus: random `c_srdy`, `p_drdy`, packet lengths 1–9.
  - Required: scoreboard matches the reassembled byte stream, masks and EOP positions exactly.

Source files
------------

// File: rtl/sd_upsize_gather.sv
// sd_upsize_gather: packs `ratio` narrow srdy/drdy beats into one wide word
// with lane mask and end-of-packet, flushing early on EOP. Output is a single
// registered word; only c_drdy sees p_drdy combinationally.
module sd_upsize_gather #(
  parameter int width = 8,
  parameter int ratio = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   c_srdy,
  output logic                   c_drdy,
  input  logic [width-1:0]       c_data,
  input  logic                   c_eop,
  output logic                   p_srdy,
  input  logic                   p_drdy,
  output logic [width*ratio-1:0] p_data,
  output logic [ratio-1:0]       p_mask,
  output logic                   p_eop
);

  localparam int CW = $clog2(ratio);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [width*ratio-1:0] acc_data_q, acc_data_d;
  logic [ratio-1:0]       acc_mask_q, acc_mask_d;
  logic [width*ratio-1:0] p_data_q, p_data_d;
  logic [ratio-1:0]       p_mask_q, p_mask_d;
  logic                   p_eop_q, p_eop_d;
  logic                   full_q, full_d;

  logic [width*ratio-1:0] merged_data;
  logic [ratio-1:0]       merged_mask;
  logic                   c_xfer;
  logic                   p_xfer;
  logic                   done;

  // Accepting is gated only by output occupancy so c_drdy never depends on data/eop.
  assign c_drdy = !full_q | p_drdy;
  assign c_xfer = c_srdy & c_drdy;
  assign p_xfer = full_q & p_drdy;
  assign done   = c_xfer & ((cnt_q == CW'(ratio - 1)) | c_eop);

  assign p_srdy = full_q;
  assign p_data = p_data_q;
  assign p_mask = p_mask_q;
  assign p_eop  = p_eop_q;

  // Accumulator contents with the incoming beat written into lane cnt.
  always_comb begin
    merged_data = acc_data_q;
    merged_mask = acc_mask_q;
    for (int unsigned k = 0; k < ratio; k++) begin
      if (cnt_q == CW'(k)) begin
        merged_data[k*width +: width] = c_data;
        merged_mask[k]                = 1'b1;
      end
    end
  end

  // Next-state: gather beats, hand a finished word to the output register.
  always_comb begin
    cnt_d      = cnt_q;
    acc_data_d = acc_data_q;
    acc_mask_d = acc_mask_q;
    p_data_d   = p_data_q;
    p_mask_d   = p_mask_q;
    p_eop_d    = p_eop_q;
    full_d     = full_q;

    if (p_xfer) begin
      full_d = 1'b0;
    end

    // A completion in the same cycle as an output transfer reloads and keeps full set.
    if (c_xfer) begin
      if (done) begin
        p_data_d   = merged_data;
        p_mask_d   = merged_mask;
        p_eop_d    = c_eop;
        full_d     = 1'b1;
        cnt_d      = '0;
        acc_data_d = '0;
        acc_mask_d = '0;
      end else begin
        acc_data_d = merged_data;
        acc_mask_d = merged_mask;
        cnt_d      = cnt_q + CW'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      acc_data_q <= '0;
      acc_mask_q <= '0;
      p_data_q   <= '0;
      p_mask_q   <= '0;
      p_eop_q    <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_data_q <= acc_data_d;
      acc_mask_q <= acc_mask_d;
      p_data_q   <= p_data_d;
      p_mask_q   <= p_mask_d;
      p_eop_q    <= p_eop_d;
      full_q     <= full_d;
    end
  end

endmodule
